// File: rtl/slave_port.sv
`default_nettype none
// ============================================================================
//  Module      : slave_port
//  Description : Serial-bus endpoint on the slave side of the system bus.
//                Shifts in address and write data LSB-first under mvalid,
//                performs one ready/valid access on the local slave memory
//                and, for reads, shifts the read data back out LSB-first
//                under svalid.
//                Optional macro SLAVE_SPLIT_EN: a slow read raises a split
//                request after SPLIT_LATENCY wait cycles and returns the data
//                only after the arbiter re-grants the master.
//  Revision    : 1.0  initial release
// ============================================================================
module slave_port #(
    parameter int ADDR_WIDTH    = 12,   // must be >= 2
    parameter int DATA_WIDTH    = 8,    // must be >= 2
    parameter int SPLIT_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  swdata,
    input  logic                  smode,
    input  logic                  mvalid,
    output logic                  srdata,
    output logic                  svalid,
    output logic                  sready,
    output logic                  ssplit,
    input  logic                  split_grant,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wen,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // One counter serves address, write-data and read-data phases, and it
    // must be able to hold DATA_WIDTH itself for the read-out end test.
    localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int AI_W    = $clog2(ADDR_WIDTH);
    localparam int DI_W    = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] c_addr_last = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] c_data_last = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] c_data_cnt  = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_MEMWR = 3'd3,
        S_MEMRD = 3'd4,
        S_RDATA = 3'd5,
        S_SPLIT = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_mode;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_svalid;
    logic                  r_srdata;

`ifdef SLAVE_SPLIT_EN
    localparam int WAIT_W = $clog2(SPLIT_LATENCY + 1);
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(SPLIT_LATENCY - 1);

    logic [WAIT_W-1:0] r_wait;      // MEMRD cycles spent without mem_ready
    logic              r_captured;  // SPLIT: read data already taken
`else
    localparam int c_unused_split_latency = SPLIT_LATENCY;
    logic          w_unused_split_grant;
    assign w_unused_split_grant = split_grant;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and memory/split handshake outputs
    always_comb begin
        w_next_state = r_state;
        mem_valid    = 1'b0;
        mem_wen      = 1'b0;
        ssplit       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mvalid) begin
                    w_next_state = S_ADDR;
                end
            end
            S_ADDR: begin
                if (mvalid && (r_cnt == c_addr_last)) begin
                    w_next_state = r_mode ? S_WDATA : S_MEMRD;
                end
            end
            S_WDATA: begin
                if (mvalid && (r_cnt == c_data_last)) begin
                    w_next_state = S_MEMWR;
                end
            end
            S_MEMWR: begin
                mem_valid = 1'b1;
                mem_wen   = 1'b1;
                if (mem_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            S_MEMRD: begin
                mem_valid = 1'b1;
                if (mem_ready) begin
                    w_next_state = S_RDATA;
                end
`ifdef SLAVE_SPLIT_EN
                // A ready arriving on the last allowed wait cycle wins.
                else if (r_wait == c_wait_last) begin
                    w_next_state = S_SPLIT;
                end
`endif
            end
            S_RDATA: begin
                if (r_cnt == c_data_cnt) begin
                    w_next_state = S_IDLE;
                end
            end
`ifdef SLAVE_SPLIT_EN
            S_SPLIT: begin
                // Keep requesting until the data is captured; ssplit falls
                // together with mem_valid on the cycle after capture.
                mem_valid = !r_captured;
                ssplit    = !r_captured;
                if (r_captured && split_grant) begin
                    w_next_state = S_RDATA;
                end
            end
`endif
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Shift registers, bit counter and registered serial read-out
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt      <= '0;
            r_mode     <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_svalid   <= 1'b0;
            r_srdata   <= 1'b0;
`ifdef SLAVE_SPLIT_EN
            r_wait     <= '0;
            r_captured <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
`ifdef SLAVE_SPLIT_EN
                    r_wait     <= '0;
                    r_captured <= 1'b0;
`endif
                    if (mvalid) begin
                        r_addr[0] <= swdata;
                        r_mode    <= smode;
                        r_cnt     <= c_one;
                    end
                end
                S_ADDR: begin
                    if (mvalid) begin
                        r_addr[r_cnt[AI_W-1:0]] <= swdata;
                        r_cnt <= (r_cnt == c_addr_last) ? '0 : r_cnt + c_one;
                    end
                end
                S_WDATA: begin
                    if (mvalid) begin
                        r_wdata[r_cnt[DI_W-1:0]] <= swdata;
                        r_cnt <= (r_cnt == c_data_last) ? '0 : r_cnt + c_one;
                    end
                end
                S_MEMRD: begin
                    // Bit 0 goes out straight from the bus so svalid starts
                    // the cycle after the handshake.
                    if (mem_ready) begin
                        r_rdata  <= mem_rdata;
                        r_svalid <= 1'b1;
                        r_srdata <= mem_rdata[0];
                        r_cnt    <= c_one;
                    end
`ifdef SLAVE_SPLIT_EN
                    else begin
                        r_wait <= r_wait + 1'b1;
                    end
`endif
                end
                S_RDATA: begin
                    if (r_cnt == c_data_cnt) begin
                        r_svalid <= 1'b0;
                        r_srdata <= 1'b0;
                        r_cnt    <= '0;
                    end else begin
                        r_srdata <= r_rdata[r_cnt[DI_W-1:0]];
                        r_cnt    <= r_cnt + c_one;
                    end
                end
`ifdef SLAVE_SPLIT_EN
                S_SPLIT: begin
                    if (!r_captured) begin
                        if (mem_ready) begin
                            r_rdata    <= mem_rdata;
                            r_captured <= 1'b1;
                        end
                    end else if (split_grant) begin
                        r_svalid   <= 1'b1;
                        r_srdata   <= r_rdata[0];
                        r_cnt      <= c_one;
                        r_captured <= 1'b0;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign sready    = (r_state == S_IDLE);
    assign svalid    = r_svalid;
    assign srdata    = r_srdata;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_slave_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slave_port
//  Description : Self-checking bench for slave_port. A memory responder
//                answers accesses after a programmable delay and a monitor
//                records handshakes, serial read-out and split activity;
//                each scenario task compares that record with values
//                derived from the transaction it generated.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_slave_port;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          swdata = 1'b0;
    logic          smode = 1'b0;
    logic          mvalid = 1'b0;
    logic          split_grant = 1'b0;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          srdata, svalid, sready, ssplit, mem_wen, mem_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    int tests  = 0;
    int failed = 0;

    slave_port #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .SPLIT_LATENCY(SL)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .swdata     (swdata),
        .smode      (smode),
        .mvalid     (mvalid),
        .srdata     (srdata),
        .svalid     (svalid),
        .sready     (sready),
        .ssplit     (ssplit),
        .split_grant(split_grant),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wen    (mem_wen),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: ready comes after rd_delay cycles of mem_valid; rdata
    // is junk except on the ready cycle.
    int            rd_delay = 0;
    logic [DW-1:0] rd_value = '0;
    initial begin : responder
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_valid) begin
                mem_ready = (wcnt == rd_delay);
                wcnt      = wcnt + 1;
            end else begin
                mem_ready = 1'b0;
                wcnt      = 0;
            end
            mem_rdata = mem_ready ? rd_value : DW'($urandom);
        end
    end

    // Monitor, sampled mid-cycle
    int            cyc = 0, n_mv = 0, n_hs = 0, n_sv = 0, n_sp = 0, n_unstable = 0;
    int            t_mv_first = -1, t_hs = -1, t_sv_first = -1, t_sv_last = -1;
    int            t_sp_first = -1, t_sp_last = -1;
    logic [DW-1:0] sv_word = '0;
    logic          hs_wen = 1'b0;
    logic [AW-1:0] hs_addr = '0;
    logic [DW-1:0] hs_wdata = '0;
    initial begin : monitor
        logic          prev_mv, prev_hs, prev_wen;
        logic [AW-1:0] prev_addr;
        logic [DW-1:0] prev_wdata;
        prev_mv = 1'b0; prev_hs = 1'b0; prev_wen = 1'b0;
        prev_addr = '0; prev_wdata = '0;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (rstn) begin
                if (mem_valid) begin
                    if (n_mv == 0) t_mv_first = cyc;
                    n_mv = n_mv + 1;
                    if (prev_mv && !prev_hs &&
                        (mem_addr !== prev_addr || mem_wdata !== prev_wdata || mem_wen !== prev_wen))
                        n_unstable = n_unstable + 1;
                    if (mem_ready) begin
                        n_hs = n_hs + 1; t_hs = cyc;
                        hs_wen = mem_wen; hs_addr = mem_addr; hs_wdata = mem_wdata;
                    end
                end
                if (svalid) begin
                    if (n_sv == 0) t_sv_first = cyc;
                    if (n_sv < DW) sv_word[n_sv] = srdata;
                    n_sv = n_sv + 1; t_sv_last = cyc;
                end
                if (ssplit) begin
                    if (n_sp == 0) t_sp_first = cyc;
                    n_sp = n_sp + 1; t_sp_last = cyc;
                end
            end
            prev_mv    = rstn && mem_valid;
            prev_hs    = mem_ready;
            prev_wen   = mem_wen;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        n_mv = 0; n_hs = 0; n_sv = 0; n_sp = 0; n_unstable = 0;
        t_mv_first = -1; t_hs = -1; t_sv_first = -1; t_sv_last = -1;
        t_sp_first = -1; t_sp_last = -1; sv_word = '0;
        hs_wen = 1'bx; hs_addr = 'x; hs_wdata = 'x;
    endtask

    // Shift n bits LSB-first with gap idle cycles after each; bus lines
    // carry junk while mvalid is low.
    task automatic send_serial(input logic [31:0] bits, input int n, input int gap, input logic mode);
        for (int i = 0; i < n; i++) begin
            swdata = bits[i];
            smode  = mode;
            mvalid = 1'b1;
            tick();
            mvalid = 1'b0;
            swdata = 1'($urandom);
            smode  = 1'($urandom);
            repeat (gap) tick();
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 200; k++) begin
            if (sready && !svalid && !mem_valid) break;
            tick();
        end
        tests++;
        if (k >= 200) begin
            failed++;
            $display("FAIL %s idle_timeout: sready=%0b svalid=%0b required sready=1 svalid=0 within 200 cycles",
                     name, sready, svalid);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input int gap, input int delay, input string name);
        clear_mon();
        rd_delay = delay;
        send_serial(32'(addr), AW, gap, 1'b1);
        send_serial(32'(data), DW - 1, gap, 1'b1);
        tests++;
        if (n_mv !== 0 || mem_valid !== 1'b0) begin
            failed++;
            $display("FAIL %s early_access: mem_valid cycles=%0d required 0", name, n_mv);
        end
        send_serial(32'(data) >> (DW - 1), 1, 0, 1'b1);
        tests++;
        if (mem_valid !== 1'b1 || mem_wen !== 1'b1) begin
            failed++;
            $display("FAIL %s write_latency: mem_valid=%0b mem_wen=%0b required 1 1", name, mem_valid, mem_wen);
        end
        wait_idle(name);
        tests++;
        if (n_hs !== 1 || hs_wen !== 1'b1 || hs_addr !== addr || hs_wdata !== data) begin
            failed++;
            $display("FAIL %s write_access: n=%0d wen=%0b addr=%h data=%h required n=1 wen=1 addr=%h data=%h",
                     name, n_hs, hs_wen, hs_addr, hs_wdata, addr, data);
        end
        tests++;
        if (n_mv !== delay + 1 || n_sv !== 0 || n_unstable !== 0 || n_sp !== 0) begin
            failed++;
            $display("FAIL %s write_protocol: mv_cycles=%0d svalid=%0d unstable=%0d ssplit=%0d required %0d 0 0 0",
                     name, n_mv, n_sv, n_unstable, n_sp, delay + 1);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input int gap, input int delay, input string name);
        clear_mon();
        rd_delay = delay;
        rd_value = data;
        send_serial(32'(addr), AW - 1, gap, 1'b0);
        tests++;
        if (n_mv !== 0 || mem_valid !== 1'b0) begin
            failed++;
            $display("FAIL %s early_access: mem_valid cycles=%0d required 0", name, n_mv);
        end
        send_serial(32'(addr) >> (AW - 1), 1, 0, 1'b0);
        tests++;
        if (mem_valid !== 1'b1 || mem_wen !== 1'b0) begin
            failed++;
            $display("FAIL %s read_request: mem_valid=%0b mem_wen=%0b required 1 0", name, mem_valid, mem_wen);
        end
        wait_idle(name);
        tests++;
        if (n_hs !== 1 || hs_wen !== 1'b0 || hs_addr !== addr) begin
            failed++;
            $display("FAIL %s read_access: n=%0d wen=%0b addr=%h required n=1 wen=0 addr=%h",
                     name, n_hs, hs_wen, hs_addr, addr);
        end
        tests++;
        if (n_sv !== DW || sv_word !== data) begin
            failed++;
            $display("FAIL %s read_data: svalid cycles=%0d word=%h required %0d %h", name, n_sv, sv_word, DW, data);
        end
        tests++;
        if (t_sv_first !== t_hs + 1 || t_sv_last - t_sv_first + 1 !== DW) begin
            failed++;
            $display("FAIL %s read_timing: first svalid=%0d last=%0d handshake=%0d required first=hs+1 span=%0d",
                     name, t_sv_first, t_sv_last, t_hs, DW);
        end
        tests++;
        if (n_mv !== delay + 1 || n_sp !== 0 || n_unstable !== 0) begin
            failed++;
            $display("FAIL %s read_protocol: mv_cycles=%0d ssplit=%0d unstable=%0d required %0d 0 0",
                     name, n_mv, n_sp, n_unstable, delay + 1);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        tests++;
        if (sready !== 1'b1 || svalid !== 1'b0 || srdata !== 1'b0 || ssplit !== 1'b0) begin
            failed++;
            $display("FAIL reset_serial: sready=%0b svalid=%0b srdata=%0b ssplit=%0b required 1 0 0 0",
                     sready, svalid, srdata, ssplit);
        end
        tests++;
        if (mem_valid !== 1'b0 || mem_wen !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            failed++;
            $display("FAIL reset_mem: valid=%0b wen=%0b addr=%h wdata=%h required 0 0 000 00",
                     mem_valid, mem_wen, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_write();
        do_write(12'hA5C, 8'h3E, 0, 0, "write_a5c");
    endtask

    task automatic test_read();
        // C9 = 1100_1001 -> LSB-first 1,0,0,1,0,0,1,1
        do_read(12'h0F1, 8'hC9, 0, 2, "read_0f1");
    endtask

    task automatic test_gapped();
        do_write(12'hA5C, 8'h3E, 3, 1, "gapped_write");
        do_read(12'h0F1, 8'hC9, 3, 2, "gapped_read");
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] a;
        a = 12'h3C7;
        clear_mon();
        send_serial(32'(a), 6, 0, 1'b1);
        swdata = a[6];
        mvalid = 1'b1;
        rstn   = 1'b0;
        tick();
        rstn   = 1'b1;
        mvalid = 1'b0;
        tests++;
        if (sready !== 1'b1 || mem_valid !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid_idle: sready=%0b mem_valid=%0b required 1 0", sready, mem_valid);
        end
        repeat (20) tick();
        tests++;
        if (n_mv !== 0 || n_sv !== 0) begin
            failed++;
            $display("FAIL reset_mid_silent: mem_valid cycles=%0d svalid cycles=%0d required 0 0", n_mv, n_sv);
        end
        do_write(12'h5A3, 8'hB4, 0, 1, "after_reset_write");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            int            g, dl;
            a  = AW'($urandom);
            d  = DW'($urandom);
            g  = $urandom_range(0, 2);
            dl = $urandom_range(0, SL - 1);
            if ($urandom_range(0, 1) == 1) do_write(a, d, g, dl, "random_write");
            else                           do_read(a, d, g, dl, "random_read");
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

`ifdef SLAVE_SPLIT_EN
    task automatic test_split();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            k;
        a = 12'h2B7;
        d = DW'($urandom);
        clear_mon();
        rd_delay = 10;
        rd_value = d;
        send_serial(32'(a), AW, 0, 1'b0);
        // A grant while ssplit is still up must be ignored.
        for (k = 0; k < 60 && n_hs == 0; k++) begin
            split_grant = (n_mv > SL + 1);
            tick();
        end
        split_grant = 1'b0;
        repeat (5) tick();
        tests++;
        if (k >= 60 || n_hs !== 1 || hs_addr !== a || hs_wen !== 1'b0) begin
            failed++;
            $display("FAIL split_access: n=%0d addr=%h wen=%0b required n=1 addr=%h wen=0", n_hs, hs_addr, hs_wen, a);
        end
        tests++;
        if (n_sp == 0 || t_sp_first !== t_mv_first + SL) begin
            failed++;
            $display("FAIL split_rise: ssplit at cycle %0d required %0d", t_sp_first, t_mv_first + SL);
        end
        tests++;
        if (t_sp_last !== t_hs || ssplit !== 1'b0 || n_mv !== 11) begin
            failed++;
            $display("FAIL split_fall: last ssplit=%0d mv_cycles=%0d required last=%0d mv_cycles=11",
                     t_sp_last, n_mv, t_hs);
        end
        tests++;
        if (n_sv !== 0) begin
            failed++;
            $display("FAIL split_no_grant: svalid cycles=%0d required 0", n_sv);
        end
        split_grant = 1'b1;
        tick();
        split_grant = 1'b0;
        tests++;
        if (svalid !== 1'b1) begin
            failed++;
            $display("FAIL split_grant_latency: svalid=%0b required 1", svalid);
        end
        wait_idle("split");
        tests++;
        if (n_sv !== DW || sv_word !== d || t_sv_last - t_sv_first + 1 !== DW) begin
            failed++;
            $display("FAIL split_data: svalid cycles=%0d word=%h required %0d %h", n_sv, sv_word, DW, d);
        end
    endtask

    task automatic test_split_edge();
        // Ready lands on the SL-th wait cycle, the one where the split
        // decision is made; do_read requires ssplit never rises.
        do_read(12'h713, 8'h5A, 0, SL - 1, "split_edge");
    endtask
`else
    task automatic test_long_wait();
        do_read(12'h2B7, 8'hA6, 0, 10, "long_wait");
    endtask
`endif

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin : main
        test_reset();
        test_write();
        test_read();
        test_gapped();
        test_reset_mid();
        test_back_to_back();
`ifdef SLAVE_SPLIT_EN
        test_split();
        test_split_edge();
`else
        test_long_wait();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
